// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_checker_pkg;

  localparam int unsigned TO_W = 8;
  localparam int unsigned RT_W = 2;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_GAP,
    ST_CMP,
    ST_FIN
  } state_t;

endpackage

// File: rtl/sysid_read_timer.sv
// Per-read stall timeout counter plus retry counter for the system-ID reader.
module sysid_read_timer
  import sysid_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic stall,
  input  logic accept,
  output logic expire,
  output logic give_up
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

  logic [TO_W-1:0] r_to_cnt;
  logic [RT_W-1:0] r_rt_cnt;

  // Expire on the stall cycle that brings the count up to TIMEOUT_CYCLES.
  assign expire  = stall && (r_to_cnt >= TO_LAST);
  assign give_up = expire && (r_rt_cnt == RT_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
      r_rt_cnt <= '0;
    end else if (clr || accept) begin
      r_to_cnt <= '0;
      r_rt_cnt <= '0;
    end else if (expire) begin
      r_to_cnt <= '0;
      if (!give_up) begin
        r_rt_cnt <= r_rt_cnt + RT_W'(1);
      end
    end else if (stall && (r_to_cnt != TO_SAT)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID, timestamp) and flags
// mismatches against compiled-in values or a bus timeout.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1403259050,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t      r_state, w_next;
  logic        r_pending;
  logic        r_word;
  logic        r_busy, r_done, r_id_ok, r_ts_ok, r_to_err;
  logic [31:0] r_id, r_ts;

  logic w_in_rd, w_stall, w_accept, w_launch, w_expire, w_give_up;

  assign w_in_rd  = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign w_stall  = w_in_rd && avm_waitrequest;
  assign w_accept = w_in_rd && !avm_waitrequest;
  assign w_launch = (r_state == ST_IDLE) && (start || r_pending);

  sysid_read_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (w_launch),
    .stall  (w_stall),
    .accept (w_accept),
    .expire (w_expire),
    .give_up(w_give_up)
  );

  always_comb begin
    w_next   = r_state;
    avm_read = 1'b0;
    case (r_state)
      ST_IDLE: if (w_launch) w_next = ST_RD_ID;
      ST_RD_ID: begin
        avm_read = 1'b1;
        if (w_accept)       w_next = ST_RD_TS;
        else if (w_give_up) w_next = ST_FIN;
        else if (w_expire)  w_next = ST_GAP;
      end
      ST_RD_TS: begin
        avm_read = 1'b1;
        if (w_accept)       w_next = ST_CMP;
        else if (w_give_up) w_next = ST_FIN;
        else if (w_expire)  w_next = ST_GAP;
      end
      // r_word remembers which read the gap must resume.
      ST_GAP:  w_next = (r_word == ADDR_TS) ? ST_RD_TS : ST_RD_ID;
      ST_CMP:  w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_pending <= AUTO_START;
      r_word    <= ADDR_ID;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_id_ok   <= 1'b0;
      r_ts_ok   <= 1'b0;
      r_to_err  <= 1'b0;
      r_id      <= '0;
      r_ts      <= '0;
    end else begin
      r_state <= w_next;
      if (start && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end else if (w_launch) begin
        r_pending <= 1'b0;
      end
      if (w_launch) begin
        r_word   <= ADDR_ID;
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
        r_id_ok  <= 1'b0;
        r_ts_ok  <= 1'b0;
        r_to_err <= 1'b0;
      end
      if (w_accept && (r_state == ST_RD_ID)) begin
        r_id   <= avm_readdata;
        r_word <= ADDR_TS;
      end
      if (w_accept && (r_state == ST_RD_TS)) begin
        r_ts <= avm_readdata;
      end
      if (r_state == ST_CMP) begin
        r_id_ok <= (r_id == EXPECTED_ID);
        r_ts_ok <= (r_ts == EXPECTED_TS);
      end
      if ((r_state == ST_CMP) || w_give_up) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_give_up) begin
        r_to_err <= 1'b1;
      end
    end
  end

  assign avm_address = r_word;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout_err = r_to_err;
  assign id_value    = r_id;
  assign ts_value    = r_ts;

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: vector table, scoreboard on done, corner sequences.
module tb_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'd1403259050;
  localparam int          TOC    = 255;
  localparam int          STUCK  = 32'h0000_FFFF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;

  always #5 clock = ~clock;

  sysid_checker #(
    .EXPECTED_ID   (32'd0),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(255),
    .MAX_RETRY     (3),
    .AUTO_START    (1'b1)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout_err    (timeout_err),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  // Slave model: stalls each read attempt for st0/st1 cycles, restarting after a gap.
  logic [31:0] slv_id = 32'd0;
  logic [31:0] slv_ts = EXP_TS;
  int          st0 = 0;
  int          st1 = 0;
  int          slv_cnt = 0;

  assign avm_waitrequest = avm_read && (slv_cnt < (avm_address ? st1 : st0));
  assign avm_readdata    = avm_address ? slv_ts : slv_id;

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) slv_cnt <= slv_cnt + 1;
    else                             slv_cnt <= 0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        err;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_id = 32'd0;
  logic [31:0] m_ts = 32'd0;

  task automatic push_exp(input logic [31:0] sid, input logic [31:0] sts, input int s0, input int s1,
                          input logic eid, input logic ets, input logic eerr);
    exp_t e;
    if (s0 < TOC) m_id = sid;
    if ((s0 < TOC) && (s1 < TOC)) m_ts = sts;
    e.id_ok = eid;
    e.ts_ok = ets;
    e.err   = eerr;
    e.idv   = m_id;
    e.tsv   = m_ts;
    sb_q.push_back(e);
  endtask

  logic done_q = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (done && !done_q) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_done actual=1 required=0");
      end else begin
        e = sb_q.pop_front();
        chk("sb_id_ok", 32'(id_ok), 32'(e.id_ok));
        chk("sb_ts_ok", 32'(ts_ok), 32'(e.ts_ok));
        chk("sb_timeout_err", 32'(timeout_err), 32'(e.err));
        chk("sb_id_value", id_value, e.idv);
        chk("sb_ts_value", ts_value, e.tsv);
      end
    end
    done_q = done;
  end

  task automatic watch(input int budget, output int lat, output int rd0, output int rd1,
                       output int rises, output logic b1, output logic d1);
    logic prev;
    lat = 0; rd0 = 0; rd1 = 0; rises = 0; b1 = 1'b0; d1 = 1'b0;
    prev = avm_read;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0;
        b1 = busy;
        d1 = done;
      end
      if (avm_read && !prev) rises++;
      if (avm_read && (avm_address == 1'b0)) rd0++;
      if (avm_read && (avm_address == 1'b1)) rd1++;
      prev = avm_read;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL watch_timeout actual=no_done required=done_within_%0d", budget);
    end
  endtask

  task automatic run_pending(input string nm, input logic [31:0] mask);
    int   dr, rr;
    logic pd, pr;
    logic dh[32];
    push_exp(32'd0, EXP_TS, 0, 0, 1'b1, 1'b1, 1'b0);
    push_exp(32'd0, EXP_TS, 0, 0, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    pd = done; pr = avm_read; dr = 0; rr = 0;
    for (int k = 1; k < 32; k++) begin
      @(negedge clock);
      start = mask[k];
      dh[k] = done;
      if (done && !pd) dr++;
      if (avm_read && !pr) rr++;
      pd = done;
      pr = avm_read;
    end
    start = 1'b0;
    chk({nm, "_done_k5"}, 32'(dh[5]), 32'd1);
    chk({nm, "_done_k6"}, 32'(dh[6]), 32'd0);
    chk({nm, "_done_k9"}, 32'(dh[9]), 32'd1);
    chk({nm, "_done_rises"}, 32'(dr), 32'd2);
    chk({nm, "_read_bursts"}, 32'(rr), 32'd2);
  endtask

  typedef struct {
    logic [31:0] sid;
    logic [31:0] sts;
    int          s0;
    int          s1;
    logic        eid;
    logic        ets;
    logic        eerr;
    int          lat;
    int          rd0;
    int          rd1;
    int          rises;
  } vec_t;

  vec_t vt[9];

  initial begin
    int   lat, rd0, rd1, rises;
    logic b1, d1;

    vt[0] = '{32'd0,        EXP_TS,         0,     0,     1'b1, 1'b1, 1'b0, 4,    1,    1,    1};
    vt[1] = '{32'd1,        EXP_TS,         0,     0,     1'b0, 1'b1, 1'b0, 4,    1,    1,    1};
    vt[2] = '{32'd0,        EXP_TS,         0,     3,     1'b1, 1'b1, 1'b0, 7,    1,    4,    1};
    vt[3] = '{32'd0,        EXP_TS + 32'd1, 2,     0,     1'b1, 1'b0, 1'b0, 6,    3,    1,    1};
    vt[4] = '{32'hFFFF_FFFF, 32'd0,         1,     1,     1'b0, 1'b0, 1'b0, 6,    2,    2,    1};
    vt[5] = '{32'd0,        EXP_TS,         254,   0,     1'b1, 1'b1, 1'b0, 258,  255,  1,    1};
    vt[6] = '{32'd5,        32'd7,          STUCK, 0,     1'b0, 1'b0, 1'b1, 1024, 1020, 0,    4};
    vt[7] = '{32'd0,        32'd9,          0,     STUCK, 1'b0, 1'b0, 1'b1, 1025, 1,    1020, 4};
    vt[8] = '{32'd3,        EXP_TS,         255,   0,     1'b0, 1'b0, 1'b1, 1024, 1020, 0,    4};

    // Reset state, then the automatic sequence on reset release.
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {28'd0, done, id_ok, ts_ok, timeout_err}, 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_values", id_value | ts_value, 32'd0);
    push_exp(32'd0, EXP_TS, 0, 0, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    watch(40, lat, rd0, rd1, rises, b1, d1);
    chk("auto_lat", 32'(lat), 32'd4);
    chk("auto_rd0", 32'(rd0), 32'd1);
    chk("auto_rd1", 32'(rd1), 32'd1);
    chk("auto_rises", 32'(rises), 32'd1);
    repeat (2) @(negedge clock);

    for (int i = 0; i < 9; i++) begin
      slv_id = vt[i].sid;
      slv_ts = vt[i].sts;
      st0    = vt[i].s0;
      st1    = vt[i].s1;
      push_exp(vt[i].sid, vt[i].sts, vt[i].s0, vt[i].s1, vt[i].eid, vt[i].ets, vt[i].eerr);
      start = 1'b1;
      watch(2000, lat, rd0, rd1, rises, b1, d1);
      chk($sformatf("v%0d_busy_k1", i), 32'(b1), 32'd1);
      chk($sformatf("v%0d_done_k1", i), 32'(d1), 32'd0);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_rd0", i), 32'(rd0), 32'(vt[i].rd0));
      chk($sformatf("v%0d_rd1", i), 32'(rd1), 32'(vt[i].rd1));
      chk($sformatf("v%0d_rises", i), 32'(rises), 32'(vt[i].rises));
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
      repeat (2) @(negedge clock);
    end

    slv_id = 32'd0; slv_ts = EXP_TS; st0 = 0; st1 = 0;
    run_pending("pend_busy", 32'h0000_000C);
    run_pending("pend_fin", 32'h0000_0010);

    // Reset while stalled on the timestamp read.
    slv_id = 32'h0000_1234; st1 = STUCK;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
    end
    chk("mid_pre_id", id_value, 32'h0000_1234);
    chk("mid_pre_rd", {30'd0, avm_read, avm_address}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_async_busy", 32'(busy), 32'd0);
    chk("mid_async_read", 32'(avm_read), 32'd0);
    chk("mid_async_id", id_value, 32'd0);
    chk("mid_async_flags", {28'd0, done, id_ok, ts_ok, timeout_err}, 32'd0);
    m_id = 32'd0;
    m_ts = 32'd0;
    repeat (2) @(negedge clock);
    slv_id = 32'd0; st1 = 0;
    push_exp(32'd0, EXP_TS, 0, 0, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    watch(40, lat, rd0, rd1, rises, b1, d1);
    chk("mid_rerun_lat", 32'(lat), 32'd4);
    chk("mid_rerun_rd1", 32'(rd1), 32'd1);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
